// File: rtl/fir_bist_pkg.sv
// Shared types and elaboration-time helpers for the FIR BIST tone sweeper.
// Holds the test FSM state type and the quarter-wave sine table generator.
package fir_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        DONE
    } bist_state_t;

    localparam int DEFAULT_IN_WIDTH       = 16;
    localparam int DEFAULT_LUT_ADDR_WIDTH = 8;
    localparam int SINE_AMPLITUDE         = (1 << (DEFAULT_IN_WIDTH - 1)) - 1;
    localparam int QUARTER_DEPTH          = 1 << (DEFAULT_LUT_ADDR_WIDTH - 2);

    function automatic int sine_amplitude(input int in_width);
        return (1 << (in_width - 1)) - 1;
    endfunction

    function automatic int quarter_depth(input int addr_width);
        return 1 << (addr_width - 2);
    endfunction

    // Entry idx of the first quadrant; the angle never reaches pi/2, so every value is >= 0.
    function automatic int quarter_entry(input int idx, input int in_width, input int addr_width);
        real angle;
        angle = 6.283185307179586 * real'(idx) / real'(1 << addr_width);
        return $rtoi(real'(sine_amplitude(in_width)) * $sin(angle) + 0.5);
    endfunction

endpackage

// File: rtl/fir_bist_sweep_sine_lut_quarter.sv
// Combinational full-wave sine lookup built from a quarter-wave table.
// Quadrants 1 and 3 read the table mirrored; quadrants 2 and 3 negate.
module sine_lut_quarter
    import fir_bist_pkg::*;
#(
    parameter int IN_WIDTH       = DEFAULT_IN_WIDTH,
    parameter int LUT_ADDR_WIDTH = DEFAULT_LUT_ADDR_WIDTH
) (
    input  logic        [LUT_ADDR_WIDTH-1:0] addr,
    output logic signed [IN_WIDTH-1:0]       sample
);

    localparam int QBITS  = LUT_ADDR_WIDTH - 2;
    localparam int QDEPTH = quarter_depth(LUT_ADDR_WIDTH);
    localparam logic signed [IN_WIDTH-1:0] AMP = IN_WIDTH'(sine_amplitude(IN_WIDTH));

    logic signed [IN_WIDTH-1:0] rom [QDEPTH];
    logic        [1:0]          quad;
    logic        [QBITS-1:0]    idx;
    logic        [QBITS-1:0]    mirror_idx;
    logic signed [IN_WIDTH-1:0] mag;

    for (genvar i = 0; i < QDEPTH; i++) begin : g_rom
        assign rom[i] = IN_WIDTH'(quarter_entry(i, IN_WIDTH, LUT_ADDR_WIDTH));
    end

    assign quad       = addr[LUT_ADDR_WIDTH-1 -: 2];
    assign idx        = addr[QBITS-1:0];
    assign mirror_idx = -idx;

    // The mirrored read at idx 0 would need entry QDEPTH (the crest), which is not stored.
    always_comb begin
        mag = rom[idx];
        if (quad[0]) mag = (idx == '0) ? AMP : rom[mirror_idx];
        sample = quad[1] ? -mag : mag;
    end

endmodule

// File: rtl/fir_bist_sweep.sv
// BIST engine for the L-parallel FIR: drives sine/DC tones into the filter,
// waits a settle window, then reports the signed peak of its outputs.
module fir_bist_sweep
    import fir_bist_pkg::*;
#(
    parameter int L              = 3,
    parameter int IN_WIDTH       = 16,
    parameter int OUT_WIDTH      = 40,
    parameter int PHASE_WIDTH    = 24,
    parameter int LUT_ADDR_WIDTH = 8,
    parameter int SETTLE_CYCLES  = 96,
    parameter int MEASURE_CYCLES = 256
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               dc_mode,
    input  logic        [PHASE_WIDTH-1:0]      phase_inc,
    output logic signed [L-1:0][IN_WIDTH-1:0]  x_out,
    input  logic signed [L-1:0][OUT_WIDTH-1:0] y_in,
    output logic                               busy,
    output logic                               done,
    output logic signed [OUT_WIDTH-1:0]        peak_out,
    output logic                               peak_valid
);

    localparam int MAX_CYCLES = (SETTLE_CYCLES > MEASURE_CYCLES) ? SETTLE_CYCLES : MEASURE_CYCLES;
    localparam int CNT_WIDTH  = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_WIDTH-1:0] SETTLE_LAST  = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] MEASURE_LAST = CNT_WIDTH'(MEASURE_CYCLES - 1);
    localparam logic signed [IN_WIDTH-1:0] DC_LEVEL = IN_WIDTH'(sine_amplitude(IN_WIDTH));

    bist_state_t                       state_q, state_d;
    logic        [PHASE_WIDTH-1:0]     inc_q, inc_d;
    logic        [PHASE_WIDTH-1:0]     acc_q, acc_d;
    logic                              dc_q, dc_d;
    logic        [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic signed [L-1:0][IN_WIDTH-1:0] x_q, x_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic signed [OUT_WIDTH-1:0]       peak_q, peak_d;
    logic                              valid_q, valid_d;

    logic        [PHASE_WIDTH-1:0]     step;
    logic signed [IN_WIDTH-1:0]        lut_sample [L];
    logic signed [OUT_WIDTH-1:0]       lane_max;

    // One clock consumes L consecutive samples of the tone.
    assign step = PHASE_WIDTH'(L) * inc_q;

    for (genvar j = 0; j < L; j++) begin : g_lane
        logic [LUT_ADDR_WIDTH-1:0] lut_addr;
        assign lut_addr = LUT_ADDR_WIDTH'((acc_q + PHASE_WIDTH'(j) * inc_q) >> (PHASE_WIDTH - LUT_ADDR_WIDTH));

        sine_lut_quarter #(
            .IN_WIDTH      (IN_WIDTH),
            .LUT_ADDR_WIDTH(LUT_ADDR_WIDTH)
        ) u_lut (
            .addr  (lut_addr),
            .sample(lut_sample[j])
        );
    end

    always_comb begin
        lane_max = y_in[0];
        for (int j = 1; j < L; j++) begin
            if ($signed(y_in[j]) > lane_max) lane_max = y_in[j];
        end
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d = state_q;
        inc_d   = inc_q;
        acc_d   = acc_q;
        dc_d    = dc_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        peak_d  = peak_q;
        valid_d = valid_q;

        if (state_q == SETTLE || state_q == MEASURE) begin
            acc_d = acc_q + step;
            for (int j = 0; j < L; j++) x_d[j] = dc_q ? DC_LEVEL : lut_sample[j];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    inc_d   = phase_inc;
                    dc_d    = dc_mode;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            MEASURE: begin
                if (cnt_q == '0 || lane_max > peak_q) peak_d = lane_max;
                if (cnt_q == MEASURE_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                x_d     = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            inc_q   <= '0;
            acc_q   <= '0;
            dc_q    <= 1'b0;
            cnt_q   <= '0;
            x_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            peak_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
            inc_q   <= inc_d;
            acc_q   <= acc_d;
            dc_q    <= dc_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            peak_q  <= peak_d;
            valid_q <= valid_d;
        end
    end

    assign x_out      = x_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign peak_out   = peak_q;
    assign peak_valid = valid_q;

endmodule

// File: tb/tb_fir_bist_sweep.sv
// Self-checking bench for fir_bist_sweep: a full-wave sine/peak model checked
// every cycle, plus hand-computed expectations for DC, Fs/4, peak and wrap cases.
module tb_fir_bist_sweep;

    localparam int L              = 3;
    localparam int IN_WIDTH       = 16;
    localparam int OUT_WIDTH      = 40;
    localparam int PHASE_WIDTH    = 24;
    localparam int LUT_ADDR_WIDTH = 8;
    localparam int S              = 96;
    localparam int M              = 256;
    localparam int TEST_LEN       = S + M + 1;
    localparam longint PHASE_MOD  = 64'd1 << PHASE_WIDTH;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic                          start;
    logic                          dc_mode;
    logic [PHASE_WIDTH-1:0]        phase_inc;
    logic [L-1:0][IN_WIDTH-1:0]    x_out;
    logic [L-1:0][OUT_WIDTH-1:0]   y_in;
    logic                          busy;
    logic                          done;
    logic [OUT_WIDTH-1:0]          peak_out;
    logic                          peak_valid;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fir_bist_sweep #(
        .L             (L),
        .IN_WIDTH      (IN_WIDTH),
        .OUT_WIDTH     (OUT_WIDTH),
        .PHASE_WIDTH   (PHASE_WIDTH),
        .LUT_ADDR_WIDTH(LUT_ADDR_WIDTH),
        .SETTLE_CYCLES (S),
        .MEASURE_CYCLES(M)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dc_mode   (dc_mode),
        .phase_inc (phase_inc),
        .x_out     (x_out),
        .y_in      (y_in),
        .busy      (busy),
        .done      (done),
        .peak_out  (peak_out),
        .peak_valid(peak_valid)
    );

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Full-wave reference: round(32767 * sin(2*pi*addr/256)), addr = top bits of phase.
    function automatic longint sine_ref(input longint phase);
        real v;
        v = 32767.0 * $sin(6.283185307179586 * real'(phase >> (PHASE_WIDTH - LUT_ADDR_WIDTH)) / 256.0);
        if (v >= 0.0) return longint'($rtoi(v + 0.5));
        return -longint'($rtoi(-v + 0.5));
    endfunction

    // Model: edges since the accepted start, latched settings, running peak.
    int                     m_t;
    bit                     m_active;
    bit                     m_done;
    bit                     m_pv;
    bit                     m_dc;
    logic [PHASE_WIDTH-1:0] m_inc;
    longint                 m_peak;

    always @(posedge clk or negedge rst_n) begin : model
        longint lm;
        if (!rst_n) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_done   <= 1'b0;
            m_pv     <= 1'b0;
            m_peak   <= 0;
            m_dc     <= 1'b0;
            m_inc    <= '0;
        end else begin
            m_done <= 1'b0;
            if (!m_active) begin
                if (start) begin
                    m_active <= 1'b1;
                    m_t      <= 0;
                    m_dc     <= dc_mode;
                    m_inc    <= phase_inc;
                    m_pv     <= 1'b0;
                end
            end else begin
                m_t <= m_t + 1;
                if (m_t + 1 >= S + 1 && m_t + 1 <= S + M) begin
                    lm = $signed(y_in[0]);
                    for (int j = 1; j < L; j++)
                        if ($signed(y_in[j]) > lm) lm = $signed(y_in[j]);
                    if (m_t + 1 == S + 1 || lm > m_peak) m_peak <= lm;
                end
                if (m_t + 1 == TEST_LEN) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                    m_pv     <= 1'b1;
                end
            end
        end
    end

    // Sample n of the tone is the (n*L + j)-th step of phase for lane j.
    function automatic longint exp_lane(input int j);
        longint ph;
        if (!m_active || m_t == 0) return 0;
        if (m_dc) return 32767;
        ph = ((longint'(m_t - 1) * L + j) * longint'(m_inc)) % PHASE_MOD;
        return sine_ref(ph);
    endfunction

    always @(negedge clk) begin : compare
        for (int j = 0; j < L; j++) check("x_lane", $signed(x_out[j]), exp_lane(j));
        check("busy", busy, m_active);
        check("done", done, m_done);
        check("peak_valid", peak_valid, m_pv);
        if (m_pv) check("peak_out", $signed(peak_out), m_peak);
    end

    int done_at;
    logic signed [63:0] x_rec [1:3][L];

    task automatic drive_y(input int mode, input int t);
        bit in_meas = (t >= S + 1 && t <= S + M);
        logic [63:0] r;
        for (int j = 0; j < L; j++) begin
            case (mode)
                0:       y_in[j] = 40'h00_4000_0000;
                1, 2:    y_in[j] = in_meas ? OUT_WIDTH'(j == 0 ? -5 : (j == 1 ? -3 : -9)) : OUT_WIDTH'(999999);
                default: begin
                    r = {$urandom, $urandom};
                    y_in[j] = r[OUT_WIDTH-1:0];
                end
            endcase
        end
        if (mode == 2 && t == S + M / 2) y_in[1] = OUT_WIDTH'(1000);
    endtask

    // Called just after a falling edge; iteration c samples just after edge k+c.
    task automatic run_test(input bit dc, input logic [PHASE_WIDTH-1:0] inc, input int mode,
                            input bit restart, input int abort_at);
        bit aborted = 1'b0;
        start     = 1'b1;
        dc_mode   = dc;
        phase_inc = inc;
        done_at   = -1;
        for (int c = 0; c < TEST_LEN + 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c >= 1 && c <= 3)
                for (int j = 0; j < L; j++) x_rec[c][j] = $signed(x_out[j]);
            if (done === 1'b1) begin
                done_at = c;
                break;
            end
            if (restart && c == 10) begin
                start     = 1'b1;
                phase_inc = ~inc;
                dc_mode   = !dc;
            end
            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                for (int j = 0; j < L; j++) check("abort_x", $signed(x_out[j]), 0);
                check("abort_busy", busy, 0);
                check("abort_peak_valid", peak_valid, 0);
                @(negedge clk);
                rst_n   = 1'b1;
                aborted = 1'b1;
                break;
            end
            drive_y(mode, c + 1);
        end
        if (!aborted && done_at < 0) check("done_timeout", 0, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        dc_mode   = 1'b0;
        phase_inc = '0;
        y_in      = '0;
        repeat (3) @(negedge clk);
        for (int j = 0; j < L; j++) check("reset_x", $signed(x_out[j]), 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_peak_valid", peak_valid, 0);
        check("reset_peak", $signed(peak_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // DC tone, constant filter output 2^30.
        run_test(1'b1, 24'h000123, 0, 1'b0, -1);
        for (int j = 0; j < L; j++) check("dc_x_first", x_rec[1][j], 32767);
        check("dc_done_latency", done_at, TEST_LEN);
        check("dc_peak", $signed(peak_out), 64'sd1073741824);
        check("dc_peak_valid", peak_valid, 1);

        // Fs/4 tone: lanes walk 0, +A, 0, -A across lanes and clocks.
        run_test(1'b0, 24'h400000, 1, 1'b0, -1);
        check("fs4_c1_l0", x_rec[1][0], 0);
        check("fs4_c1_l1", x_rec[1][1], 32767);
        check("fs4_c1_l2", x_rec[1][2], 0);
        check("fs4_c2_l0", x_rec[2][0], -32767);
        check("fs4_c2_l1", x_rec[2][1], 0);
        check("fs4_c2_l2", x_rec[2][2], 32767);
        check("fs4_c3_l0", x_rec[3][0], 0);
        check("fs4_c3_l1", x_rec[3][1], -32767);
        check("fs4_c3_l2", x_rec[3][2], 0);
        check("neg_peak", $signed(peak_out), -3);

        // One positive spike in the middle of an all-negative window.
        run_test(1'b0, 24'h012345, 2, 1'b0, -1);
        check("inject_peak", $signed(peak_out), 1000);

        // Second start during SETTLE must be ignored.
        run_test(1'b0, 24'h051EB8, 3, 1'b1, -1);
        check("restart_done_latency", done_at, TEST_LEN);

        // Reset in the middle of MEASURE, then a clean full run.
        run_test(1'b0, 24'h020000, 3, 1'b0, S + 50);
        repeat (4) @(negedge clk);
        check("post_abort_peak", $signed(peak_out), 0);
        check("post_abort_valid", peak_valid, 0);
        check("post_abort_done", done, 0);
        run_test(1'b0, 24'h030000, 1, 1'b0, -1);
        check("after_abort_latency", done_at, TEST_LEN);
        check("after_abort_peak", $signed(peak_out), -3);

        // Increment of -1 LSB: phase wraps immediately below zero.
        run_test(1'b0, 24'hFFFFFF, 1, 1'b0, -1);
        check("wrap_c1_l0", x_rec[1][0], 0);
        check("wrap_c1_l1", x_rec[1][1], -804);
        check("wrap_c1_l2", x_rec[1][2], -804);
        check("wrap_peak_valid", peak_valid, 1);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
